// File: rtl/pwm_duty_decoder.sv
// Receive-side PWM decoder: measures period and high time of a PWM input and
// recovers the 5-bit duty value through a 6-step restoring divider.
module pwm_duty_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             clr_overrun,
  output logic [4:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic             duty_valid,
  output logic             stuck,
  output logic             overrun
);
  localparam int DIV_W = CNT_W + 5;

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_STUCK} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             div_busy_q, div_busy_d;
  logic [2:0]       div_step_q, div_step_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] dsr_q, dsr_d;
  logic [4:0]       quo_q, quo_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [4:0]       duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             overrun_q, overrun_d;

  logic             level, rise, cnt_full;
  logic             start_div, drop, enter_stuck, leave_stuck;
  logic [CNT_W-1:0] p_meas;
  logic             div_bit, div_done;
  logic [5:0]       quo_final;

  assign level    = s2_q;
  assign rise     = s2_q & ~s3_q;
  assign cnt_full = (period_cnt_q == '1);
  // Period saturates rather than wrapping when an edge lands on a full counter.
  assign p_meas   = cnt_full ? period_cnt_q : period_cnt_q + CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (rise) state_d = S_MEASURE;
      S_MEASURE: if (!rise && cnt_full) state_d = S_STUCK;
      S_STUCK:   if (rise) state_d = S_MEASURE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    start_div   = 1'b0;
    drop        = 1'b0;
    enter_stuck = 1'b0;
    leave_stuck = 1'b0;
    unique case (state_q)
      S_MEASURE: begin
        start_div   = rise & ~div_busy_q;
        drop        = rise & div_busy_q;
        enter_stuck = ~rise & cnt_full;
      end
      S_STUCK: leave_stuck = rise;
      default: ;
    endcase
  end

  always_comb begin
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    if (rise) begin
      period_cnt_d = '0;
      high_cnt_d   = CNT_W'(1);
    end else if (state_q == S_MEASURE) begin
      if (!cnt_full) period_cnt_d = period_cnt_q + CNT_W'(1);
      if (level && high_cnt_q != '1) high_cnt_d = high_cnt_q + CNT_W'(1);
    end
  end

  // Divisor starts at P<<5 and shifts right one bit per step, yielding
  // quotient bits 5..0; step 6 is the hold cycle in which outputs are shown.
  assign div_bit   = (rem_q >= dsr_q);
  assign quo_final = {quo_q, div_bit};
  assign div_done  = div_busy_q && (div_step_q == 3'd5);

  always_comb begin
    div_busy_d = div_busy_q;
    div_step_d = div_step_q;
    rem_d      = rem_q;
    dsr_d      = dsr_q;
    quo_d      = quo_q;
    p_d        = p_q;
    if (start_div) begin
      div_busy_d = 1'b1;
      div_step_d = 3'd0;
      rem_d      = {high_cnt_q, 5'b0};
      dsr_d      = {p_meas, 5'b0};
      quo_d      = '0;
      p_d        = p_meas;
    end else if (div_busy_q) begin
      if (div_step_q == 3'd6) begin
        div_busy_d = 1'b0;
      end else begin
        if (div_bit) rem_d = rem_q - dsr_q;
        dsr_d      = dsr_q >> 1;
        quo_d      = quo_final[4:0];
        div_step_d = div_step_q + 3'd1;
      end
    end
  end

  always_comb begin
    duty_d    = duty_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    stuck_d   = stuck_q;
    if (div_done) begin
      duty_d   = quo_final[5] ? 5'd31 : quo_final[4:0];
      period_d = p_q;
      valid_d  = 1'b1;
    end else if (enter_stuck) begin
      duty_d   = level ? 5'd31 : 5'd0;
      period_d = '1;
      valid_d  = 1'b1;
    end
    if (enter_stuck)      stuck_d = 1'b1;
    else if (leave_stuck) stuck_d = 1'b0;
    overrun_d = drop | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      div_busy_q   <= 1'b0;
      div_step_q   <= '0;
      rem_q        <= '0;
      dsr_q        <= '0;
      quo_q        <= '0;
      p_q          <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      s1_q         <= pwm_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      div_busy_q   <= div_busy_d;
      div_step_q   <= div_step_d;
      rem_q        <= rem_d;
      dsr_q        <= dsr_d;
      quo_q        <= quo_d;
      p_q          <= p_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      overrun_q    <= overrun_d;
    end
  end

  assign duty       = duty_q;
  assign period     = period_q;
  assign duty_valid = valid_q;
  assign stuck      = stuck_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: a timestamp-based reference model built from the
// sampled input history, compared every cycle, plus hand-computed scenarios.
module tb_pwm_duty_decoder;
  localparam int CNT_W = 12;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_in = 1'b0;
  logic             clr_overrun = 1'b0;
  logic [4:0]       duty;
  logic [CNT_W-1:0] period;
  logic             duty_valid, stuck, overrun;

  pwm_duty_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .clr_overrun(clr_overrun),
    .duty(duty), .period(period), .duty_valid(duty_valid),
    .stuck(stuck), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: works on absolute edge indices of the sampled input.
  bit hist[$];
  int cyc = -1;
  int armed = -1, div_start = -100, pend_t = -1, last_drop = -1;
  int pend_duty, pend_period;
  int duty_m = 0, period_m = 0;
  bit dv_m = 0, stuck_m = 0, ovr_m = 0;

  function automatic bit lvl(int j);
    return (j >= 0) ? hist[j] : 1'b0;
  endfunction

  task automatic model_step();
    bit level, rise, drop;
    int p, h;
    cyc++;
    if (rst) begin
      hist.push_back(1'b0);
      if (cyc >= 1) hist[cyc-1] = 1'b0;
      if (cyc >= 2) hist[cyc-2] = 1'b0;
      armed = -1; div_start = -100; pend_t = -1; last_drop = -1;
      duty_m = 0; period_m = 0; dv_m = 0; stuck_m = 0; ovr_m = 0;
    end else begin
      hist.push_back(pwm_in);
      drop  = 1'b0;
      dv_m  = 1'b0;
      level = lvl(cyc - 2);
      rise  = level & !lvl(cyc - 3);
      if (pend_t == cyc) begin
        duty_m = pend_duty; period_m = pend_period; dv_m = 1'b1; pend_t = -1;
      end
      if (rise) begin
        if (armed >= 0 && !stuck_m) begin
          p = cyc - armed;
          if (p > MAXC) p = MAXC;
          h = 0;
          for (int j = armed; j < cyc; j++) h += int'(lvl(j - 2));
          if (h > MAXC) h = MAXC;
          if (cyc >= div_start + 8) begin
            div_start   = cyc;
            pend_t      = cyc + 6;
            pend_period = p;
            pend_duty   = (32 * h) / p;
            if (pend_duty > 31) pend_duty = 31;
          end else begin
            drop = 1'b1;
            last_drop = cyc;
          end
        end
        stuck_m = 1'b0;
        armed   = cyc;
      end else if (armed >= 0 && !stuck_m && cyc - armed == MAXC + 1) begin
        stuck_m  = 1'b1;
        duty_m   = level ? 31 : 0;
        period_m = MAXC;
        dv_m     = 1'b1;
      end
      if (drop)             ovr_m = 1'b1;
      else if (clr_overrun) ovr_m = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  int dv_duty_q[$];
  int dv_per_q[$];

  initial forever begin
    @(negedge clk);
    if (cyc >= 0) begin
      check("duty", duty, duty_m);
      check("period", period, period_m);
      check("duty_valid", duty_valid, dv_m);
      check("stuck", stuck, stuck_m);
      check("overrun", overrun, ovr_m);
      if (duty_valid) begin
        dv_duty_q.push_back(duty);
        dv_per_q.push_back(period);
      end
    end
  end

  function automatic int log_duty(int i);
    return (i < dv_duty_q.size()) ? dv_duty_q[i] : -1;
  endfunction

  function automatic int log_per(int i);
    return (i < dv_per_q.size()) ? dv_per_q[i] : -1;
  endfunction

  task automatic drive(input bit v);
    pwm_in = v;
    @(negedge clk);
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  task automatic burst(input int p, input int h, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < p; j++) drive(j < h);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base, budget;
  bit rand_run;

  initial begin
    // Reset state
    do_reset();
    check("rst_duty", duty, 0);
    check("rst_period", period, 0);
    check("rst_valid", duty_valid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_overrun", overrun, 0);

    // 50% duty, period 1024
    base = dv_duty_q.size();
    burst(1024, 512, 3);
    hold(1'b1, 16);
    hold(1'b0, 30);
    check("A_count", dv_duty_q.size() - base, 3);
    check("A_duty", log_duty(base + 2), 16);
    check("A_period", log_per(base + 2), 1024);

    // LED-style frame (32 steps x 64 cycles), value 20, then value 0
    do_reset();
    base = dv_duty_q.size();
    burst(2048, 1280, 2);
    hold(1'b1, 1280);
    hold(1'b0, 4200);
    check("B_count", dv_duty_q.size() - base, 3);
    check("B_duty0", log_duty(base), 20);
    check("B_duty1", log_duty(base + 1), 20);
    check("B_period1", log_per(base + 1), 2048);
    check("B_stuck_duty", log_duty(base + 2), 0);
    check("B_stuck_period", log_per(base + 2), MAXC);
    check("B_stuck", stuck, 1);

    // Near-full duty, then held high until stuck, then recovery
    do_reset();
    base = dv_duty_q.size();
    burst(1024, 1023, 2);
    hold(1'b1, 4200);
    check("C_count", dv_duty_q.size() - base, 3);
    check("C_duty0", log_duty(base), 31);
    check("C_duty1", log_duty(base + 1), 31);
    check("C_stuck_duty", log_duty(base + 2), 31);
    check("C_stuck", stuck, 1);
    hold(1'b0, 10);
    base = dv_duty_q.size();
    hold(1'b1, 8);
    check("C_unstuck", stuck, 0);
    check("C_no_valid_on_edge", dv_duty_q.size() - base, 0);
    hold(1'b1, 504);
    hold(1'b0, 512);
    hold(1'b1, 16);
    hold(1'b0, 20);
    check("C_recover_count", dv_duty_q.size() - base, 1);
    check("C_recover_duty", log_duty(base), 16);
    check("C_recover_period", log_per(base), 1024);

    // Period-4 square wave: overrun and its clear priority
    do_reset();
    fork
      burst(4, 2, 20);
      begin
        budget = 60;
        while (last_drop < 0 && budget > 0) begin
          @(negedge clk);
          budget--;
        end
        check("D_overrun_set", overrun, 1);
        while (cyc != last_drop + 7 && budget > 0) begin
          @(negedge clk);
          budget--;
        end
        check("D_wait_budget", int'(budget > 0), 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("D_clr_vs_drop", overrun, 1);
      end
    join
    hold(1'b0, 10);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("D_clr_alone", overrun, 0);

    // Reset while a division is in flight
    do_reset();
    base = dv_duty_q.size();
    hold(1'b1, 512);
    hold(1'b0, 512);
    hold(1'b1, 5);
    rst = 1'b1;
    pwm_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(1'b0, 20);
    check("E_no_valid", dv_duty_q.size() - base, 0);
    check("E_duty", duty, 0);
    check("E_period", period, 0);
    check("E_stuck", stuck, 0);
    check("E_overrun", overrun, 0);
    burst(1024, 512, 1);
    check("E_one_rise", dv_duty_q.size() - base, 0);
    hold(1'b1, 16);
    hold(1'b0, 20);
    check("E_two_rises", dv_duty_q.size() - base, 1);
    check("E_duty_after", log_duty(base), 16);

    // Minimum period without overrun
    do_reset();
    base = dv_duty_q.size();
    burst(8, 1, 6);
    hold(1'b1, 1);
    hold(1'b0, 20);
    check("F_count", dv_duty_q.size() - base, 6);
    for (int i = 0; i < 6; i++) check("F_duty", log_duty(base + i), 4);
    check("F_period", log_per(base + 5), 8);
    check("F_overrun", overrun, 0);

    // Randomized bursts with random clears and occasional resets
    rand_run = 1'b1;
    fork
      begin
        for (int it = 0; it < 20; it++) begin
          int p, h, n;
          p = int'($urandom_range(2, 300));
          h = int'($urandom_range(1, p - 1));
          n = int'($urandom_range(2, 4));
          if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            drive(1'($urandom_range(0, 1)));
            rst = 1'b0;
          end
          burst(p, h, n);
        end
        hold(1'b0, 20);
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          clr_overrun = ($urandom_range(0, 15) == 0);
          @(negedge clk);
        end
        clr_overrun = 1'b0;
      end
    join

    hold(1'b0, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Measures a single-bit PWM waveform and recovers its 5-bit duty value (0-31) and period in clock cycles. It is the receive-side counterpart of the LED PWM generators: a 32-level PWM produced by a 5-bit ticker decodes back to the value that generated it. Used for loopback test of LED/PWM outputs and for reading externally generated PWM inputs.

## Interface

- CNT_W, 16, width of period/high-time counters; timeout at 2^CNT_W-1 cycles
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- pwm_in  input  1  PWM waveform, asynchronous to clk
- clr_overrun  input  1  single-cycle pulse clears `overrun`
- duty  output  5  last decoded duty, floor(32*H/P) clamped to 31
- period  output  CNT_W  last measured period P in cycles
- duty_valid  output  1  one-cycle strobe: `duty`/`period` updated
- stuck  output  1  no rising edge for 2^CNT_W-1 cycles
- overrun  output  1  sticky: edge arrived while divider busy

## Operation

- Input path: 3-flop chain s1<=pwm_in, s2<=s1, s3<=s2; level = s2; rise = s2 & ~s3.
- States: IDLE (reset; no edge seen), MEASURE, STUCK.
- IDLE: on rise -> MEASURE, period_cnt<=0, high_cnt<=1; no output.
- MEASURE, each non-rise cycle: period_cnt+=1, high_cnt+=level; both saturate at all-ones.
- MEASURE, on rise: P = period_cnt+1, H = high_cnt (high cycles in [prev edge, this edge-1]); counters restart (period_cnt<=0, high_cnt<=1); if divider idle, start division, else drop sample and set overrun.
- Division: restoring, numerator H<<5 (CNT_W+5 bits), divisor P, 6-bit quotient in 6 iteration cycles; result clamped to 31 (H=P gives 32 -> 31).
- MEASURE, period_cnt reaches 2^CNT_W-1 without rise -> STUCK: duty<=31 if level else 0, period<=all-ones, stuck<=1, one duty_valid pulse on entry.
- STUCK: on rise -> MEASURE with counters restarted as in IDLE; stuck<=0 that cycle; no output for that edge.
- overrun: set by dropped sample; cleared by clr_overrun or rst; set wins if both occur in the same cycle.
- Arithmetic: P>=1 always; H<=P guaranteed by counter rules; saturated counters never wrap.

## Timing

- Reset values: duty=0, period=0, duty_valid=0, stuck=0, overrun=0, state IDLE, s1..s3=0, divider idle.
- pwm_in sampled high at clock n -> rise true in cycle n+2.
- Divider busy cycles e+1..e+7 for edge cycle e; duty, period and duty_valid update in cycle e+7; duty_valid high exactly one cycle.
- Minimum period without overrun: 8 cycles. Edge at e+7 or earlier -> overrun, running division still completes and outputs.
- STUCK entry: duty_valid and stuck assert in cycle following the cycle period_cnt reaches all-ones.
- rst mid-division aborts it; no duty_valid follows.
- duty/period hold between strobes.

## Test plan

- P=1024, H=512 steady; three periods -> duty_valid from the 2nd rise onward, duty=16, period=1024, 7 cycles after each rise.
- LED-style PWM: period 32768, high 20*1024 cycles -> duty=20 for every measurement; repeat v=0 (never high) gives stuck, duty=0, period=all-ones.
- P=1024, H=1023 -> duty=31; pwm_in held high after a rise -> after 65535 cycles stuck=1, duty=31, one duty_valid pulse; next rise clears stuck, first valid one period later.
- P=4 square wave -> overrun=1 within 8 cycles of second rise; clr_overrun pulse coincident with a new drop -> overrun stays 1; clr_overrun alone -> 0.
- rst asserted 3 cycles after a rise (division in flight) -> no duty_valid, all outputs at reset values, first new valid only after two further rises.
- P=8, H=1 steady -> duty=4 every period, no overrun.
